// File: rtl/decimator_pkg.sv
// decimator_pkg: FSM state types and counter sizing shared by the decimator blocks
package decimator_pkg;
  typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} tx_state_t;
  function automatic int cnt_width(input int factor);
    return factor > 1 ? $clog2(factor) : 1;
  endfunction
endpackage

// File: rtl/decimator_if.sv
// decimator_if: upstream and downstream four-phase req/ack channels plus FIFO occupancy
interface decimator_if #(
  parameter int DataWidth = 18,
  parameter int FifoDepth = 4
);
  localparam int LevelWidth = $clog2(FifoDepth) + 1;
  logic [DataWidth-1:0]  data_in_i;
  logic                  data_in_req_i;
  logic                  data_in_ack_o;
  logic [DataWidth-1:0]  data_out_o;
  logic                  data_out_req_o;
  logic                  data_out_ack_i;
  logic [LevelWidth-1:0] level_o;
  modport master (
    output data_in_i, data_in_req_i, data_out_ack_i,
    input  data_in_ack_o, data_out_o, data_out_req_o, level_o
  );
  modport slave (
    input  data_in_i, data_in_req_i, data_out_ack_i,
    output data_in_ack_o, data_out_o, data_out_req_o, level_o
  );
endinterface

// File: rtl/decimator_sample_fifo.sv
// sample_fifo: synchronous FIFO with combinational head; pointers wrap modulo Depth
module sample_fifo #(
  parameter int DataWidth = 18,
  parameter int Depth     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DataWidth-1:0]     wdata,
  output logic [DataWidth-1:0]     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);
  localparam int AW = $clog2(Depth);
  logic [DataWidth-1:0] mem [Depth];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  always_comb begin
    full    = level == (AW+1)'(Depth);
    empty   = level == '0;
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem[rptr];
  end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
  always_ff @(posedge clk)
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      wptr  <= do_push ? wptr + AW'(1) : wptr;
      rptr  <= do_pop ? rptr + AW'(1) : rptr;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/decimator.sv
// decimator: keeps one of every Factor handshaken samples, buffers them and re-emits over req/ack
module decimator
  import decimator_pkg::*;
#(
  parameter int DataWidth = 18,
  parameter int Factor    = 4,
  parameter int FifoDepth = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  decimator_if.slave bus
);
  localparam int CW = cnt_width(Factor);
  localparam logic [CW-1:0] Last = CW'(Factor - 1);
  rx_state_t rx_q, rx_d;
  tx_state_t tx_q, tx_d;
  logic [CW-1:0] cnt_q;
  logic [DataWidth-1:0] head, dout_q;
  logic keep, accept, push, pop, load, full, empty;
  sample_fifo #(.DataWidth(DataWidth), .Depth(FifoDepth)) fifo (
    .clk(clk_i), .rst(rst_i), .push(push), .pop(pop), .wdata(bus.data_in_i),
    .rdata(head), .full(full), .empty(empty), .level(bus.level_o)
  );
  // Dropped samples are acked even when the FIFO is full; only kept ones stall.
  always_comb begin
    keep   = cnt_q == '0;
    accept = rx_q == RX_IDLE && bus.data_in_req_i && (!keep || !full);
    push   = accept && keep;
    rx_d   = rx_q == RX_IDLE ? (accept ? RX_ACK : RX_IDLE) : (bus.data_in_req_i ? RX_ACK : RX_IDLE);
    load   = tx_q == TX_IDLE && !empty;
    pop    = tx_q == TX_REQ && bus.data_out_ack_i;
    tx_d   = load ? TX_REQ : pop ? TX_WAIT : (tx_q == TX_WAIT && !bus.data_out_ack_i) ? TX_IDLE : tx_q;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      rx_q   <= RX_IDLE;
      tx_q   <= TX_IDLE;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      cnt_q  <= accept ? (cnt_q == Last ? '0 : cnt_q + CW'(1)) : cnt_q;
      dout_q <= load ? head : dout_q;
    end
  assign bus.data_in_ack_o  = rx_q == RX_ACK;
  assign bus.data_out_req_o = tx_q == TX_REQ;
  assign bus.data_out_o     = dout_q;
endmodule

// File: tb/tb_decimator.sv
// tb_decimator: scoreboard bench for a Factor=4 and a Factor=1 decimator sharing clock and reset
module tb_decimator;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  decimator_if #(.DataWidth(18), .FifoDepth(4)) ia();
  decimator_if #(.DataWidth(18), .FifoDepth(4)) ib();
  decimator #(.DataWidth(18), .Factor(4), .FifoDepth(4)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ia));
  decimator #(.DataWidth(18), .Factor(1), .FifoDepth(4)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ib));
  int checks = 0, failures = 0;
  int mcnt_a = 0, dlv_a = 0, dlv_b = 0;
  logic [17:0] qa[$], qb[$];
  logic sink_a = 1, sink_b = 1;
  logic auto_ack_a = 0, auto_ack_b = 0, man_ack_a = 0, man_ack_b = 0;
  assign ia.data_out_ack_i = sink_a ? auto_ack_a : man_ack_a;
  assign ib.data_out_ack_i = sink_b ? auto_ack_b : man_ack_b;
  initial begin
    ia.data_in_i = '0; ia.data_in_req_i = 0;
    ib.data_in_i = '0; ib.data_in_req_i = 0;
  end
  // Auto sinks: compare each new output against the scoreboard, then ack it.
  always @(negedge clk)
    if (rst) auto_ack_a = 0;
    else if (sink_a && ia.data_out_req_o && !auto_ack_a) begin
      checks++;
      if (qa.size() == 0) begin
        failures++; $display("FAIL out_a unexpected sample got=%0h", ia.data_out_o);
      end else begin
        if (ia.data_out_o !== qa[0]) begin
          failures++; $display("FAIL out_a got=%0h required=%0h", ia.data_out_o, qa[0]);
        end
        void'(qa.pop_front());
      end
      dlv_a++; auto_ack_a = 1;
    end else if (!ia.data_out_req_o) auto_ack_a = 0;
  always @(negedge clk)
    if (rst) auto_ack_b = 0;
    else if (sink_b && ib.data_out_req_o && !auto_ack_b) begin
      checks++;
      if (qb.size() == 0) begin
        failures++; $display("FAIL out_b unexpected sample got=%0h", ib.data_out_o);
      end else begin
        if (ib.data_out_o !== qb[0]) begin
          failures++; $display("FAIL out_b got=%0h required=%0h", ib.data_out_o, qb[0]);
        end
        void'(qb.pop_front());
      end
      dlv_b++; auto_ack_b = 1;
    end else if (!ib.data_out_req_o) auto_ack_b = 0;

  task automatic do_reset(input int n);
    @(negedge clk); rst = 1;
    repeat (n) @(negedge clk);
    rst = 0;
    qa.delete(); qb.delete();
    mcnt_a = 0; dlv_a = 0; dlv_b = 0; man_ack_a = 0; man_ack_b = 0;
  endtask

  task automatic send_a(input logic [17:0] d);
    int n = 0;
    if (mcnt_a == 0) qa.push_back(d);
    mcnt_a = (mcnt_a + 1) % 4;
    ia.data_in_i = d; ia.data_in_req_i = 1;
    do begin @(negedge clk); n++; end while (!ia.data_in_ack_o && n < 50);
    checks++;
    if (ia.data_in_ack_o !== 1'b1) begin failures++; $display("FAIL ack_a_rise d=%0h ack=%b required=1", d, ia.data_in_ack_o); end
    ia.data_in_req_i = 0; n = 0;
    do begin @(negedge clk); n++; end while (ia.data_in_ack_o && n < 50);
    checks++;
    if (ia.data_in_ack_o !== 1'b0) begin failures++; $display("FAIL ack_a_fall d=%0h ack=%b required=0", d, ia.data_in_ack_o); end
  endtask

  task automatic send_b(input logic [17:0] d);
    int n = 0;
    qb.push_back(d);
    ib.data_in_i = d; ib.data_in_req_i = 1;
    do begin @(negedge clk); n++; end while (!ib.data_in_ack_o && n < 50);
    checks++;
    if (ib.data_in_ack_o !== 1'b1) begin failures++; $display("FAIL ack_b_rise d=%0h ack=%b required=1", d, ib.data_in_ack_o); end
    ib.data_in_req_i = 0; n = 0;
    do begin @(negedge clk); n++; end while (ib.data_in_ack_o && n < 50);
    checks++;
    if (ib.data_in_ack_o !== 1'b0) begin failures++; $display("FAIL ack_b_fall d=%0h ack=%b required=0", d, ib.data_in_ack_o); end
  endtask

  task automatic drain_a(input int n_exp);
    int n = 0;
    while ((qa.size() != 0 || ia.data_out_req_o) && n < 300) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() != 0) begin failures++; $display("FAIL drain_a pending=%0d required=0", qa.size()); end
    checks++;
    if (dlv_a != n_exp) begin failures++; $display("FAIL count_a delivered=%0d required=%0d", dlv_a, n_exp); end
  endtask

  task automatic drain_b(input int n_exp);
    int n = 0;
    while ((qb.size() != 0 || ib.data_out_req_o) && n < 300) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (qb.size() != 0) begin failures++; $display("FAIL drain_b pending=%0d required=0", qb.size()); end
    checks++;
    if (dlv_b != n_exp) begin failures++; $display("FAIL count_b delivered=%0d required=%0d", dlv_b, n_exp); end
  endtask

  task automatic test_reset();
    ia.data_in_i = 18'h7; ia.data_in_req_i = 1;
    @(negedge clk); rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ia.data_in_ack_o, ia.data_out_req_o, ia.data_out_o, ia.level_o} !== '0) begin
      failures++; $display("FAIL reset_a ack=%b req=%b data=%0h level=%0d required all 0",
        ia.data_in_ack_o, ia.data_out_req_o, ia.data_out_o, ia.level_o);
    end
    checks++;
    if ({ib.data_in_ack_o, ib.data_out_req_o, ib.data_out_o, ib.level_o} !== '0) begin
      failures++; $display("FAIL reset_b ack=%b req=%b data=%0h level=%0d required all 0",
        ib.data_in_ack_o, ib.data_out_req_o, ib.data_out_o, ib.level_o);
    end
    checks++;
    if (dut_a.cnt_q !== '0) begin failures++; $display("FAIL reset_cnt got=%0d required=0", dut_a.cnt_q); end
    rst = 0;
    qa.delete(); mcnt_a = 0; dlv_a = 0;
    send_a(18'h7);
    drain_a(1);
  endtask

  task automatic test_decimate();
    do_reset(2);
    for (int i = 1; i <= 12; i++) send_a(18'(i));
    drain_a(3);
  endtask

  task automatic test_back_pressure();
    int n = 0;
    do_reset(2);
    sink_b = 0;
    for (int i = 1; i <= 4; i++) send_b(18'h100 + 18'(i));
    checks++;
    if (ib.level_o !== 3'd4) begin failures++; $display("FAIL bp_level got=%0d required=4", ib.level_o); end
    qb.push_back(18'h105);
    ib.data_in_i = 18'h105; ib.data_in_req_i = 1;
    repeat (10) @(negedge clk);
    checks++;
    if (ib.data_in_ack_o !== 1'b0) begin failures++; $display("FAIL bp_stall ack=%b required=0", ib.data_in_ack_o); end
    sink_b = 1;
    while (!ib.data_in_ack_o && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (ib.data_in_ack_o !== 1'b1) begin failures++; $display("FAIL bp_release ack=%b required=1", ib.data_in_ack_o); end
    ib.data_in_req_i = 0;
    drain_b(5);
  endtask

  task automatic test_latency();
    logic ok = 1;
    do_reset(2);
    sink_a = 0;
    mcnt_a = 1;
    ia.data_in_i = 18'h155; ia.data_in_req_i = 1;
    @(negedge clk);
    checks++;
    if (ia.data_in_ack_o !== 1'b1 || ia.data_out_req_o !== 1'b0) begin
      failures++; $display("FAIL lat_t ack=%b req_out=%b required 1,0", ia.data_in_ack_o, ia.data_out_req_o);
    end
    @(negedge clk);
    checks++;
    if (ia.data_out_req_o !== 1'b1 || ia.data_out_o !== 18'h155) begin
      failures++; $display("FAIL lat_t1 req_out=%b data=%0h required 1,155", ia.data_out_req_o, ia.data_out_o);
    end
    ia.data_in_req_i = 0;
    repeat (3) begin @(negedge clk); ok &= ia.data_out_o === 18'h155 && ia.data_out_req_o === 1'b1; end
    checks++;
    if (!ok) begin failures++; $display("FAIL lat_hold data=%0h req_out=%b required 155,1", ia.data_out_o, ia.data_out_req_o); end
    man_ack_a = 1;
    @(negedge clk);
    checks++;
    if (ia.data_out_req_o !== 1'b0 || ia.data_out_o !== 18'h155) begin
      failures++; $display("FAIL lat_pop req_out=%b data=%0h required 0,155", ia.data_out_req_o, ia.data_out_o);
    end
    man_ack_a = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (ia.data_out_o !== 18'h155 || ia.level_o !== '0) begin
      failures++; $display("FAIL lat_after data=%0h level=%0d required 155,0", ia.data_out_o, ia.level_o);
    end
    sink_a = 1;
  endtask

  task automatic test_push_pop();
    int n = 0;
    do_reset(2);
    sink_b = 0;
    send_b(18'h0AA);
    send_b(18'h0BB);
    checks++;
    if (ib.level_o !== 3'd2 || ib.data_out_req_o !== 1'b1) begin
      failures++; $display("FAIL pp_pre level=%0d req_out=%b required 2,1", ib.level_o, ib.data_out_req_o);
    end
    checks++;
    if (ib.data_out_o !== qb[0]) begin failures++; $display("FAIL pp_head got=%0h required=%0h", ib.data_out_o, qb[0]); end
    void'(qb.pop_front());
    qb.push_back(18'h0CC);
    ib.data_in_i = 18'h0CC; ib.data_in_req_i = 1; man_ack_b = 1;
    @(negedge clk);
    checks++;
    if (ib.level_o !== 3'd2 || ib.data_in_ack_o !== 1'b1 || ib.data_out_req_o !== 1'b0) begin
      failures++; $display("FAIL pp_same level=%0d ack=%b req_out=%b required 2,1,0",
        ib.level_o, ib.data_in_ack_o, ib.data_out_req_o);
    end
    ib.data_in_req_i = 0; man_ack_b = 0; sink_b = 1;
    while (ib.data_in_ack_o && n < 50) begin @(negedge clk); n++; end
    drain_b(2);
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    sink_b = 0;
    send_a(18'h2A);
    for (int i = 0; i < 3; i++) send_b(18'h200 + 18'(i));
    checks++;
    if (ib.level_o !== 3'd3 || ib.data_out_req_o !== 1'b1 || int'(dut_a.cnt_q) != mcnt_a) begin
      failures++; $display("FAIL rm_pre level=%0d req_out=%b cnt_a=%0d required 3,1,%0d",
        ib.level_o, ib.data_out_req_o, dut_a.cnt_q, mcnt_a);
    end
    do_reset(1);
    checks++;
    if (ib.data_out_req_o !== 1'b0 || ib.level_o !== '0 || dut_a.cnt_q !== '0 || dut_b.cnt_q !== '0) begin
      failures++; $display("FAIL rm_post req_out=%b level=%0d cnt_a=%0d cnt_b=%0d required 0,0,0,0",
        ib.data_out_req_o, ib.level_o, dut_a.cnt_q, dut_b.cnt_q);
    end
    sink_b = 1;
    send_a(18'h3B);
    drain_a(1);
    drain_b(0);
  endtask

  initial begin
    test_reset();
    test_decimate();
    test_back_pressure();
    test_latency();
    test_push_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
